// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multiplier: product width and minimum latency.
// Also defines MULT_PKG_CHECK_PARAMS, an elaboration-time guard for WIDTH/LATENCY.
// Optional build macro used by mult_pipe: MULT_PIPE_SIGNED_EN (two's-complement multiply).

package mult_pkg;

  // Shortest legal go-to-out_valid distance: the input capture register alone.
  localparam int MIN_LATENCY = 1;

  // Full-precision product width for a given operand width.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// Place inside a module body; stops elaboration on illegal parameters.
`define MULT_PKG_CHECK_PARAMS(W, L) \
  if ((W) < 1 || (L) < mult_pkg::MIN_LATENCY) begin : g_bad_params \
    $error("mult_pipe: WIDTH must be >= 1 and LATENCY must be >= 1"); \
  end

// File: rtl/mult_delay_reg.sv
// Valid+data shift register, DEPTH stages, data forced to 0 when not valid.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// No backpressure: a new entry may enter every cycle.

module mult_delay_reg
  import mult_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_shift
      logic [DEPTH-1:0]  v_q;
      logic [DATA_W-1:0] d_q [DEPTH];

      // Shift valid and data one stage per cycle; invalid slots carry zero data.
      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= '0;
          for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
          v_q[0] <= in_valid;
          d_q[0] <= in_valid ? in_data : '0;
          for (int i = 1; i < DEPTH; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= v_q[i-1] ? d_q[i-1] : '0;
          end
        end
      end

      assign out_valid = v_q[DEPTH-1];
      assign out_data  = d_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined WIDTH x WIDTH multiplier with full 2*WIDTH product (signed when MULT_PIPE_SIGNED_EN).
// Latency: LATENCY cycles from go to out_valid; operands needed only in the go cycle.
// No backpressure: accepts a new operand pair every cycle; out is 0 whenever out_valid is 0.

module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   left,
  input  logic [WIDTH-1:0]   right,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid
);

  localparam int PW = prod_width(WIDTH);

  `MULT_PKG_CHECK_PARAMS(WIDTH, LATENCY)

  logic [WIDTH-1:0] left_q;
  logic [WIDTH-1:0] right_q;
  logic             v0_q;
  logic [PW-1:0]    left_ext;
  logic [PW-1:0]    right_ext;
  logic [PW-1:0]    prod;

  // Capture operands on go; idle cycles load zeros so the multiplier sees a quiet input.
  always_ff @(posedge clk) begin
    if (reset) begin
      left_q  <= '0;
      right_q <= '0;
      v0_q    <= 1'b0;
    end else begin
      left_q  <= go ? left  : '0;
      right_q <= go ? right : '0;
      v0_q    <= go;
    end
  end

`ifdef MULT_PIPE_SIGNED_EN
  assign left_ext  = {{WIDTH{left_q[WIDTH-1]}},  left_q};
  assign right_ext = {{WIDTH{right_q[WIDTH-1]}}, right_q};
`else
  assign left_ext  = {{WIDTH{1'b0}}, left_q};
  assign right_ext = {{WIDTH{1'b0}}, right_q};
`endif

  // Low PW bits of the extended product are exact for both signed and unsigned operands.
  assign prod = left_ext * right_ext;

  // Remaining LATENCY-1 stages; zero depth makes the output combinational from stage 0.
  mult_delay_reg #(
    .DATA_W (PW),
    .DEPTH  (LATENCY - 1)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v0_q),
    .in_data   (prod),
    .out_valid (out_valid),
    .out_data  (out)
  );

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: several width/latency instances share one stimulus stream.
// Expected outputs come from a cycle-indexed history of go/operands/reset and plain arithmetic.
// Follows the build's MULT_PIPE_SIGNED_EN setting for the reference product.

module tb_mult_pipe;

  localparam int NI   = 6;
  localparam int MAXE = 700;
  localparam int WS [NI] = '{32, 32, 4, 8, 1, 16};
  localparam int LS [NI] = '{2, 3, 1, 2, 1, 5};

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;

  logic [63:0] o0, o1;
  logic [7:0]  o2;
  logic [15:0] o3;
  logic [1:0]  o4;
  logic [31:0] o5;
  logic        v0, v1, v2, v3, v4, v5;

  int checks = 0;
  int errors = 0;
  int e = 0;

  logic        go_h  [MAXE];
  logic        rst_h [MAXE];
  logic [31:0] l_h   [MAXE];
  logic [31:0] r_h   [MAXE];

  always #5 clk = ~clk;

  mult_pipe #(.WIDTH(32), .LATENCY(2)) u0 (.clk(clk), .reset(reset), .go(go),
    .left(left), .right(right), .out(o0), .out_valid(v0));
  mult_pipe #(.WIDTH(32), .LATENCY(3)) u1 (.clk(clk), .reset(reset), .go(go),
    .left(left), .right(right), .out(o1), .out_valid(v1));
  mult_pipe #(.WIDTH(4), .LATENCY(1)) u2 (.clk(clk), .reset(reset), .go(go),
    .left(left[3:0]), .right(right[3:0]), .out(o2), .out_valid(v2));
  mult_pipe #(.WIDTH(8), .LATENCY(2)) u3 (.clk(clk), .reset(reset), .go(go),
    .left(left[7:0]), .right(right[7:0]), .out(o3), .out_valid(v3));
  mult_pipe #(.WIDTH(1), .LATENCY(1)) u4 (.clk(clk), .reset(reset), .go(go),
    .left(left[0:0]), .right(right[0:0]), .out(o4), .out_valid(v4));
  mult_pipe #(.WIDTH(16), .LATENCY(5)) u5 (.clk(clk), .reset(reset), .go(go),
    .left(left[15:0]), .right(right[15:0]), .out(o5), .out_valid(v5));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Mathematical product of the low w bits of a and b, reduced to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m1, m2, ea, eb;
    m1 = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ea = {32'd0, a} & m1;
    eb = {32'd0, b} & m1;
`ifdef MULT_PIPE_SIGNED_EN
    if (ea[w-1]) ea = ea | ~m1;
    if (eb[w-1]) eb = eb | ~m1;
`endif
    return (ea * eb) & m2;
  endfunction

  // Compare every instance against the history after edge k.
  task automatic check_all(input int k);
    for (int i = 0; i < NI; i++) begin
      logic [63:0] got, exp;
      logic        gv, ev;
      int          s;
      case (i)
        0: begin got = o0;              gv = v0; end
        1: begin got = o1;              gv = v1; end
        2: begin got = {56'd0, o2};     gv = v2; end
        3: begin got = {48'd0, o3};     gv = v3; end
        4: begin got = {62'd0, o4};     gv = v4; end
        default: begin got = {32'd0, o5}; gv = v5; end
      endcase
      s  = k - LS[i] + 1;
      ev = (s >= 0) && go_h[s];
      if (ev) for (int j = s; j <= k; j++) if (rst_h[j]) ev = 1'b0;
      exp = ev ? ref_prod(WS[i], l_h[s], r_h[s]) : 64'd0;
      check($sformatf("u%0d_valid_e%0d", i, k), {63'd0, gv}, {63'd0, ev});
      check($sformatf("u%0d_out_e%0d", i, k), got, exp);
    end
  endtask

  // One clock: drive inputs, record them at the edge, check after the edge.
  task automatic cyc(input logic g, input logic [31:0] a, input logic [31:0] b, input logic rs);
    go = g; left = a; right = b; reset = rs;
    @(posedge clk);
    if (e < MAXE) begin
      go_h[e] = g; l_h[e] = a; r_h[e] = b; rst_h[e] = rs;
    end
    @(negedge clk);
    if (e < MAXE) check_all(e);
    e++;
  endtask

  initial begin
    go = 1'b0; left = '0; right = '0; reset = 1'b1;
    @(negedge clk);
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    check("reset_out_u0", o0, 64'd0);
    check("reset_valid_u1", {63'd0, v1}, 64'd0);
    cyc(1'b0, 0, 0, 1'b0);

    // 7*6 = 42 on the LATENCY=2 instance, exactly two cycles after go.
    cyc(1'b1, 7, 6, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    check("dir_u0_42", o0, 64'd42);
    check("dir_u0_42_vld", {63'd0, v0}, 64'd1);
    cyc(1'b0, 0, 0, 1'b0);
    check("dir_u0_after", {63'd0, v0}, 64'd0);
    cyc(1'b0, 0, 0, 1'b0);

    // Full range, no truncation.
    cyc(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
`ifndef MULT_PIPE_SIGNED_EN
    check("dir_u0_full", o0, 64'hFFFF_FFFE_0000_0001);
`else
    check("dir_u0_full", o0, 64'd1);
`endif
    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);

    // Back-to-back issue.
    cyc(1'b1, 1, 2, 1'b0);
    cyc(1'b1, 3, 4, 1'b0);
    cyc(1'b1, 5, 6, 1'b0);
    check("dir_u1_first", o1, 64'd2);
    cyc(1'b1, 7, 8, 1'b0);
    check("dir_u1_second", o1, 64'd12);
    cyc(1'b0, 0, 0, 1'b0);
    check("dir_u1_third", o1, 64'd30);
    cyc(1'b0, 0, 0, 1'b0);
    check("dir_u1_fourth", o1, 64'd56);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0);

    // Reset mid-flight; go in the reset cycle is ignored.
    cyc(1'b1, 9, 9, 1'b0);
    cyc(1'b1, 1, 1, 1'b1);
    cyc(1'b1, 2, 3, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    check("dir_u1_killed", {63'd0, v1}, 64'd0);
    cyc(1'b0, 0, 0, 1'b0);
    check("dir_u1_after_rst", o1, 64'd6);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0);

    // Sign-sensitive pattern on the 8-bit instance.
    cyc(1'b1, 32'h0000_00FE, 32'h0000_0003, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
`ifdef MULT_PIPE_SIGNED_EN
    check("dir_u3_sign", {48'd0, o3}, 64'h0000_0000_0000_FFFA);
`else
    check("dir_u3_sign", {48'd0, o3}, 64'h0000_0000_0000_02FA);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b0);

    // LATENCY=1, WIDTH=4.
    cyc(1'b1, 15, 15, 1'b0);
`ifdef MULT_PIPE_SIGNED_EN
    check("dir_u2_max", {56'd0, o2}, 64'h01);
`else
    check("dir_u2_max", {56'd0, o2}, 64'hE1);
`endif
    cyc(1'b1, 15, 15, 1'b1);
    check("dir_u2_rst_go", {63'd0, v2}, 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 0, 1'b0);

    // Random traffic with occasional resets and all-ones operands.
    for (int n = 0; n < 450; n++) begin
      logic        g, rs;
      logic [31:0] a, b;
      g  = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 31) == 0);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '1;
      cyc(g, a, b, rs);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
